// File: rtl/otter_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// otter_pipe_ctrl
//
// Central hazard, flush and interrupt-entry sequencer for the 5-stage OTTER
// pipeline (IF/ID/EX/MEM/WB).
//
// Each cycle in RUN the block resolves the following conditions in priority
// order:
//   1. taken EX redirect,
//   2. pending interrupt entry,
//   3. load-use hazard,
//   4. normal flow.
//
// Interrupt entry walks RUN -> DRAIN (DRAIN_CYCLES cycles) -> TRAP -> RUN.
// EPC is captured from the IF/ID PC on the entry cycle. INTR_ACK pulses in TRAP.
//
// Parameters:
//   DRAIN_CYCLES  cycles spent in DRAIN before the trap redirect (legal 1..7)
//
// Ports:
//   CLOCK, RESET          clock, synchronous active-high reset
//   INTR, MIE             level interrupt request, interrupt enable
//   ID_RS1/2, ID_USES_RS1/2, ID_PC
//                         source fields, use flags and PC of the IF/ID instr.
//   EX_MEMREAD, EX_RD     ID/EX instruction is a load, and its destination
//   EX_PCSOURCE           EX branch decision; nonzero = taken redirect
//   PC_WRITE              PC register enable
//   IF_ID_WRITE           IF/ID register enable
//   IF_ID_FLUSH           load NOP into IF/ID
//   ID_EX_FLUSH           zero the write/read controls entering ID/EX
//   PC_SEL_INTR           PC mux selects the trap vector
//   INTR_ACK              one-cycle pulse: CSR saves EPC and clears MIE
//   EPC                   captured return PC
//   STALL_CNT, FLUSH_CNT  (PIPE_CTRL_PERF_EN only) load-use stall cycles and
//                         taken-redirect cycles, free-running
//
// Build option:
//   PIPE_CTRL_PERF_EN  when defined, adds the STALL_CNT / FLUSH_CNT counters.
// -----------------------------------------------------------------------------
module otter_pipe_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        INTR,
  input  logic        MIE,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic [31:0] ID_PC,
  input  logic        EX_MEMREAD,
  input  logic [4:0]  EX_RD,
  input  logic [1:0]  EX_PCSOURCE,
  output logic        PC_WRITE,
  output logic        IF_ID_WRITE,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_FLUSH,
  output logic        PC_SEL_INTR,
  output logic        INTR_ACK,
  output logic [31:0] EPC
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] STALL_CNT,
  output logic [31:0] FLUSH_CNT
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        pend_q,  pend_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic [31:0] epc_q,   epc_d;

  // Hazard detect: x0 is never a real producer, and a source field only
  // matters when the decoded instruction actually reads it.
  logic rs1_hit, rs2_hit, load_use;
  assign rs1_hit  = ID_USES_RS1 && (ID_RS1 == EX_RD);
  assign rs2_hit  = ID_USES_RS2 && (ID_RS2 == EX_RD);
  assign load_use = EX_MEMREAD && (EX_RD != 5'd0) && (rs1_hit || rs2_hit);

  // Per-cycle decisions while in RUN, also used by the performance counters.
  logic redirect, stall;
  assign redirect = (state_q == ST_RUN) && (EX_PCSOURCE != 2'b00);
  assign stall    = (state_q == ST_RUN) && !redirect && !pend_q && load_use;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned; a missing default would infer a latch.
    state_d     = state_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    epc_d       = epc_q;
    PC_WRITE    = 1'b1;
    IF_ID_WRITE = 1'b1;
    IF_ID_FLUSH = 1'b0;
    ID_EX_FLUSH = 1'b0;
    PC_SEL_INTR = 1'b0;
    INTR_ACK    = 1'b0;

    // Requests are only latched in RUN; once set, pend survives INTR
    // dropping and is only retired by TRAP (or reset).
    if ((state_q == ST_RUN) && INTR && MIE) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      ST_RUN: begin
        if (redirect) begin
          // Squash the two younger instructions; entry waits a cycle so
          // EPC captures the redirected path rather than a squashed PC.
          IF_ID_FLUSH = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end else if (pend_q) begin
          // Entry: freeze fetch, capture the return PC, and empty IF/ID and
          // ID/EX so only EX and MEM remain to retire during DRAIN.
          PC_WRITE    = 1'b0;
          IF_ID_FLUSH = 1'b1;
          ID_EX_FLUSH = 1'b1;
          epc_d       = ID_PC;
          cnt_d       = 3'(DRAIN_CYCLES);
          state_d     = ST_DRAIN;
        end else if (load_use) begin
          // One bubble: hold PC and IF/ID, inject a NOP into ID/EX.
          PC_WRITE    = 1'b0;
          IF_ID_WRITE = 1'b0;
          ID_EX_FLUSH = 1'b1;
        end
      end

      ST_DRAIN: begin
        // EX holds a bubble here, so EX_PCSOURCE is deliberately ignored.
        PC_WRITE    = 1'b0;
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
        cnt_d       = 3'(cnt_q - 3'd1);
        if (cnt_q == 3'd1) begin
          state_d = ST_TRAP;
        end
      end

      ST_TRAP: begin
        PC_SEL_INTR = 1'b1;
        INTR_ACK    = 1'b1;
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
        pend_d      = 1'b0;
        state_d     = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Reset is synchronous, so state may still read DRAIN/TRAP during the
    // RESET cycle. Forcing the outputs here means an abort can never leak
    // an INTR_ACK or a trap-vector select.
    if (RESET) begin
      PC_WRITE    = 1'b1;
      IF_ID_WRITE = 1'b1;
      IF_ID_FLUSH = 1'b0;
      ID_EX_FLUSH = 1'b0;
      PC_SEL_INTR = 1'b0;
      INTR_ACK    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples its _d value from the same pre-edge snapshot.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
      cnt_q   <= 3'd0;
      epc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
    end
  end

  assign EPC = epc_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_otter_pipe_ctrl
//
// Scoreboard bench for otter_pipe_ctrl with DRAIN_CYCLES = 2.
//
// Stimulus process:
//   - applies one input vector per cycle, 1 ns after the rising edge;
//   - pushes the hand-computed expected control vector for that cycle.
//
// Monitor process:
//   - pops one entry on every falling edge and compares it against the DUT.
//
// Control vector bit order:
//   {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, PC_SEL_INTR, INTR_ACK}
// -----------------------------------------------------------------------------
module tb_otter_pipe_ctrl;

  localparam logic [5:0] V_NORM  = 6'b110000;
  localparam logic [5:0] V_STALL = 6'b000100;
  localparam logic [5:0] V_REDIR = 6'b111100;
  localparam logic [5:0] V_ENTRY = 6'b011100;
  localparam logic [5:0] V_DRAIN = 6'b011100;
  localparam logic [5:0] V_TRAP  = 6'b111111;
  localparam logic [5:0] V_RST   = 6'b110000;

  logic        clk;
  logic        rst;
  logic        intr, mie;
  logic [4:0]  rs1, rs2, ex_rd;
  logic        u1, u2, memread;
  logic [31:0] id_pc;
  logic [1:0]  pcsrc;

  logic        pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic        pc_sel_intr, intr_ack;
  logic [31:0] epc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  otter_pipe_ctrl #(.DRAIN_CYCLES(2)) dut (
    .CLOCK       (clk),
    .RESET       (rst),
    .INTR        (intr),
    .MIE         (mie),
    .ID_RS1      (rs1),
    .ID_RS2      (rs2),
    .ID_USES_RS1 (u1),
    .ID_USES_RS2 (u2),
    .ID_PC       (id_pc),
    .EX_MEMREAD  (memread),
    .EX_RD       (ex_rd),
    .EX_PCSOURCE (pcsrc),
    .PC_WRITE    (pc_write),
    .IF_ID_WRITE (if_id_write),
    .IF_ID_FLUSH (if_id_flush),
    .ID_EX_FLUSH (id_ex_flush),
    .PC_SEL_INTR (pc_sel_intr),
    .INTR_ACK    (intr_ack),
    .EPC         (epc)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .STALL_CNT   (stall_cnt),
    .FLUSH_CNT   (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  ctrl;
    bit          chk_epc;
    logic [31:0] epc;
    bit          chk_perf;
    logic [31:0] stall_n;
    logic [31:0] flush_n;
    string       name;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Staged inputs for the next cycle.
  logic        s_rst, s_intr, s_mie, s_u1, s_u2, s_memread;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [31:0] s_pc;
  logic [1:0]  s_pcsrc;

  // Optional expectations attached to the next cycle.
  bit          x_chk_epc;
  logic [31:0] x_epc;
  bit          x_chk_perf;
  logic [31:0] x_stall, x_flush;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    s_rst     = 1'b0;
    s_intr    = 1'b0;
    s_mie     = 1'b1;
    s_rs1     = 5'd1;
    s_rs2     = 5'd2;
    s_u1      = 1'b0;
    s_u2      = 1'b0;
    s_pc      = 32'd0;
    s_memread = 1'b0;
    s_rd      = 5'd0;
    s_pcsrc   = 2'b00;
  endtask

  task automatic want_epc(input logic [31:0] v);
    x_chk_epc = 1'b1;
    x_epc     = v;
  endtask

  task automatic want_perf(input logic [31:0] st, input logic [31:0] fl);
    x_chk_perf = 1'b1;
    x_stall    = st;
    x_flush    = fl;
  endtask

  // Apply the staged vector for one cycle and queue its expected response.
  task automatic go(input logic [5:0] ctrl, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst     = s_rst;
    intr    = s_intr;
    mie     = s_mie;
    rs1     = s_rs1;
    rs2     = s_rs2;
    u1      = s_u1;
    u2      = s_u2;
    id_pc   = s_pc;
    memread = s_memread;
    ex_rd   = s_rd;
    pcsrc   = s_pcsrc;

    e.ctrl     = ctrl;
    e.chk_epc  = x_chk_epc;
    e.epc      = x_epc;
    e.chk_perf = x_chk_perf;
    e.stall_n  = x_stall;
    e.flush_n  = x_flush;
    e.name     = name;
    sb.push_back(e);

    x_chk_epc  = 1'b0;
    x_chk_perf = 1'b0;
  endtask

  // Monitor: one expected entry per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {pc_write, if_id_write, if_id_flush, id_ex_flush,
               pc_sel_intr, intr_ack};
        check({e.name, ".ctrl"}, {26'd0, act}, {26'd0, e.ctrl});
        if (e.chk_epc) begin
          check({e.name, ".epc"}, epc, e.epc);
        end
`ifdef PIPE_CTRL_PERF_EN
        if (e.chk_perf) begin
          check({e.name, ".stall_cnt"}, stall_cnt, e.stall_n);
          check({e.name, ".flush_cnt"}, flush_cnt, e.flush_n);
        end
`endif
      end
    end
  end

  initial begin
    x_chk_epc  = 1'b0;
    x_chk_perf = 1'b0;
    x_epc      = 32'd0;
    x_stall    = 32'd0;
    x_flush    = 32'd0;

    idle();
    rst     = 1'b1;
    intr    = 1'b0;
    mie     = 1'b1;
    rs1     = 5'd1;
    rs2     = 5'd2;
    u1      = 1'b0;
    u2      = 1'b0;
    id_pc   = 32'd0;
    memread = 1'b0;
    ex_rd   = 5'd0;
    pcsrc   = 2'b00;
    repeat (2) @(posedge clk);

    // Reset values: during RESET and on the following cycle.
    idle(); s_rst = 1'b1; want_epc(32'd0); go(V_RST,  "reset_hold");
    idle();               want_epc(32'd0); go(V_NORM, "reset_after");

    // Load-use on rs1, then release.
    idle(); s_memread = 1; s_rd = 5; s_rs1 = 5; s_u1 = 1;
    go(V_STALL, "loaduse_rs1");
    idle(); go(V_NORM, "loaduse_release");

    // x0 destination never stalls.
    idle(); s_memread = 1; s_rd = 0; s_rs1 = 0; s_u1 = 1;
    go(V_NORM, "x0_filter");

    // rs2 match ignored when rs2 is not read.
    idle(); s_memread = 1; s_rd = 7; s_rs2 = 7; s_u2 = 0; s_rs1 = 3; s_u1 = 1;
    go(V_NORM, "unused_rs2");

    // rs2 match honoured when rs2 is read.
    idle(); s_memread = 1; s_rd = 7; s_rs2 = 7; s_u2 = 1;
    go(V_STALL, "loaduse_rs2");

    // Redirect beats a simultaneous load-use.
    idle(); s_pcsrc = 2'b01; s_memread = 1; s_rd = 5; s_rs1 = 5; s_u1 = 1;
    go(V_REDIR, "redirect_over_loaduse");
    idle(); s_pcsrc = 2'b10;
    go(V_REDIR, "redirect_10");
    idle(); go(V_NORM, "post_redirect");

    // INTR with MIE=0 is ignored.
    idle(); s_mie = 0; s_intr = 1; go(V_NORM, "mie0_a");
    idle(); s_mie = 0;             go(V_NORM, "mie0_b");
    idle();                        go(V_NORM, "mie0_c");

    // Interrupt entry: ACK in the fifth cycle counting the INTR cycle.
    // A redirect during DRAIN must be ignored.
    idle(); s_intr = 1; s_pc = 32'h40;      go(V_NORM,  "irq_c0");
    idle(); s_pc = 32'h40; want_epc(32'h0); go(V_ENTRY, "irq_entry");
    idle(); s_pc = 32'h44; s_pcsrc = 2'b01; want_epc(32'h40);
    go(V_DRAIN, "irq_drain1");
    idle(); want_epc(32'h40);               go(V_DRAIN, "irq_drain2");
    idle(); want_epc(32'h40);               go(V_TRAP,  "irq_trap");
    idle();                                 go(V_NORM,  "irq_after");

    // Deferred entry: the redirect coincides with pend, so EPC takes the
    // next cycle's ID_PC. Pend also outranks a load-use on the entry cycle.
    idle(); s_intr = 1; s_pc = 32'h100;     go(V_NORM,  "def_c0");
    idle(); s_pc = 32'h104; s_pcsrc = 2'b01; go(V_REDIR, "def_redirect");
    idle(); s_pc = 32'h108; s_memread = 1; s_rd = 9; s_rs1 = 9; s_u1 = 1;
    go(V_ENTRY, "def_entry");
    idle(); want_epc(32'h108);              go(V_DRAIN, "def_drain1");
    idle();                                 go(V_DRAIN, "def_drain2");
    idle(); want_epc(32'h108);              go(V_TRAP,  "def_trap");
    idle();                                 go(V_NORM,  "def_after");

    // Reset in the second DRAIN cycle aborts entry. Counts so far:
    // 2 stalls and 3 redirect cycles.
    idle(); s_intr = 1; s_pc = 32'h200;     go(V_NORM,  "rst_c0");
    idle(); s_pc = 32'h200;                 go(V_ENTRY, "rst_entry");
    idle(); want_epc(32'h200); want_perf(32'd2, 32'd3);
    go(V_DRAIN, "rst_drain1");
    idle(); s_rst = 1; want_epc(32'h200);   go(V_RST,   "rst_in_drain");
    idle(); want_epc(32'd0); want_perf(32'd0, 32'd0);
    go(V_RST, "rst_released");
    idle(); go(V_NORM, "rst_no_ack1");
    idle(); go(V_NORM, "rst_no_ack2");
    idle(); want_epc(32'd0); go(V_NORM, "rst_no_ack3");

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0",
               sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
